// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
//   clog2      : ceiling log2, used to size pointers and the level counter
//   FIFO_STD   : registered read, one cycle of latency after rd_en
//   FIFO_FWFT  : first-word-fall-through, head word visible without a read
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Circular pointer register for a FIFO of arbitrary depth.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear to entry 0 (takes priority over inc)
//   inc      : advance by one entry
//   ptr      : current pointer, always in 0..DEPTH-1
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Wrap is an explicit compare so non-power-of-two depths never index
    // past the last entry.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read mode,
// programmable almost flags, synchronous flush and sticky error flags.
//   clk, rst        : clock, asynchronous active-low reset
//   flush           : clear contents on the next edge, overrides wr/rd
//   wr_en, data_in  : write request and data
//   rd_en           : read request (pop in FWFT mode)
//   data_out        : read data
//   rd_valid        : data_out carries a freshly read word (FWFT: head valid)
//   full, empty     : level == DEPTH, level == 0
//   almost_full     : level >= AF_LEVEL
//   almost_empty    : level <= AE_LEVEL
//   level           : current occupancy
//   overflow        : sticky, write attempted while full
//   underflow       : sticky, read attempted while empty
//   clr_err         : clear overflow/underflow (a same-cycle event wins)
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            data_in,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            data_out,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [clog2(DEPTH+1)-1:0]   level,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        clr_err
);

    localparam int PW = clog2(DEPTH);
    localparam int LW = clog2(DEPTH + 1);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "fifo_sync_prog: DEPTH must be at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_sync_prog: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL > DEPTH) begin : g_bad_ae
        $fatal(1, "fifo_sync_prog: AE_LEVEL must not exceed DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [LW-1:0]    level_q,    level_d;
    logic [WIDTH-1:0] dout_q,     dout_d;
    logic             rdv_q,      rdv_d;
    logic             ovf_q,      ovf_d;
    logic             unf_q,      unf_d;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come from the registered level only, so accept decisions use
    // start-of-cycle state: a same-cycle read never frees room for a write
    // into a full FIFO, and a same-cycle write never feeds a read from empty.
    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AF_LEVEL));
    assign almost_empty = (level_q <= LW'(AE_LEVEL));

    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    always_comb begin
        level_d = level_q;
        dout_d  = dout_q;
        rdv_d   = 1'b0;
        ovf_d   = (ovf_q & ~clr_err) | (wr_en & full  & ~flush);
        unf_d   = (unf_q & ~clr_err) | (rd_en & empty & ~flush);
        if (flush) begin
            level_d = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        if (FWFT == FIFO_STD && rd_acc) begin
            dout_d = mem_q[rd_ptr];
            rdv_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            dout_q  <= '0;
            rdv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            dout_q  <= dout_d;
            rdv_q   <= rdv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately left unreset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= data_in;
        end
    end

    assign data_out  = (FWFT == FIFO_FWFT) ? mem_q[rd_ptr] : dout_q;
    assign rd_valid  = (FWFT == FIFO_FWFT) ? ~empty : rdv_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Two FIFO instances share one random stimulus stream: a DEPTH=8 standard
// FIFO and a DEPTH=5 FWFT FIFO. Each is compared every cycle against a
// queue-based reference model.
module tb_fifo_sync_prog;

    localparam int DA = 8, AFA = 6, AEA = 2;
    localparam int DB = 5, AFB = 4, AEB = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, wr_en, rd_en, clr_err;
    logic [7:0] data_in;

    logic [7:0] dout_a, dout_b;
    logic       rdv_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic       rdv_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [3:0] lvl_a;
    logic [2:0] lvl_b;

    fifo_sync_prog #(.WIDTH(8), .DEPTH(DA), .AF_LEVEL(AFA), .AE_LEVEL(AEA), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout_a), .rd_valid(rdv_a), .full(full_a),
        .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a), .level(lvl_a),
        .overflow(ovf_a), .underflow(unf_a), .clr_err(clr_err)
    );

    fifo_sync_prog #(.WIDTH(8), .DEPTH(DB), .AF_LEVEL(AFB), .AE_LEVEL(AEB), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout_b), .rd_valid(rdv_b), .full(full_b),
        .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b), .level(lvl_b),
        .overflow(ovf_b), .underflow(unf_b), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int         dep [2] = '{DA, DB};
    int         afl [2] = '{AFA, AFB};
    int         ael [2] = '{AEA, AEB};
    bit         fw  [2] = '{1'b0, 1'b1};
    logic [7:0] mq  [2][$];
    bit         m_ovf [2];
    bit         m_unf [2];
    bit         m_rdv [2];
    logic [7:0] m_dout [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_one(input int i, input logic [7:0] dout, input logic rdv,
                             input logic full, input logic empty, input logic af,
                             input logic ae, input logic [31:0] lvl,
                             input logic ovf, input logic unf);
        int n;
        string p;
        n = mq[i].size();
        p = (i == 0) ? "std" : "fwft";
        chk({p, " level"},        lvl,   n);
        chk({p, " full"},         full,  n == dep[i]);
        chk({p, " empty"},        empty, n == 0);
        chk({p, " almost_full"},  af,    n >= afl[i]);
        chk({p, " almost_empty"}, ae,    n <= ael[i]);
        chk({p, " overflow"},     ovf,   m_ovf[i]);
        chk({p, " underflow"},    unf,   m_unf[i]);
        if (fw[i]) begin
            chk({p, " rd_valid"}, rdv, n != 0);
            if (n != 0) chk({p, " data_out"}, dout, mq[i][0]);
        end else begin
            chk({p, " rd_valid"}, rdv,  m_rdv[i]);
            chk({p, " data_out"}, dout, m_dout[i]);
        end
    endtask

    task automatic check_all();
        check_one(0, dout_a, rdv_a, full_a, empty_a, af_a, ae_a, 32'(lvl_a), ovf_a, unf_a);
        check_one(1, dout_b, rdv_b, full_b, empty_b, af_b, ae_b, 32'(lvl_b), ovf_b, unf_b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
            m_rdv[i]  = 1'b0;
            m_dout[i] = 8'h00;
        end
    endtask

    // Applies the inputs currently driven as the effect of the next edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int   n;
            bit   is_full, is_empty;
            logic [7:0] d;
            n        = mq[i].size();
            is_full  = (n == dep[i]);
            is_empty = (n == 0);
            if (clr_err) begin
                m_ovf[i] = 1'b0;
                m_unf[i] = 1'b0;
            end
            m_rdv[i] = 1'b0;
            if (flush) begin
                mq[i].delete();
            end else begin
                if (wr_en && is_full)  m_ovf[i] = 1'b1;
                if (rd_en && is_empty) m_unf[i] = 1'b1;
                if (rd_en && !is_empty) begin
                    d = mq[i].pop_front();
                    if (!fw[i]) begin
                        m_dout[i] = d;
                        m_rdv[i]  = 1'b1;
                    end
                end
                if (wr_en && !is_full) mq[i].push_back(data_in);
            end
        end
    endtask

    task automatic idle_inputs();
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic run_phase(input int cycles, input int wr_pct, input int rd_pct);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_all();
            wr_en   = ($urandom_range(0, 99) < wr_pct);
            rd_en   = ($urandom_range(0, 99) < rd_pct);
            flush   = ($urandom_range(0, 99) < 2);
            clr_err = ($urandom_range(0, 99) < 4);
            data_in = 8'($urandom_range(0, 255));
            model_step();
        end
        @(negedge clk);
        check_all();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Read from empty straight out of reset.
        @(negedge clk);
        rd_en = 1'b1;
        model_step();
        @(negedge clk);
        check_all();
        idle_inputs();

        // Fill, overflow, drain, balanced, then mixed rates with flushes.
        run_phase(40,  95,  5);
        run_phase(40,   5, 95);
        run_phase(150, 50, 50);
        run_phase(200, 70, 30);
        run_phase(200, 30, 70);

        // Asynchronous reset between edges with a partly filled FIFO.
        run_phase(6, 100, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b1;

        run_phase(300, 55, 45);
        run_phase(100, 90, 90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
